// File: rtl/pipe_invariant_monitor.sv
// ---------------------------------------------------------------------------
// pipe_invariant_monitor
//
// Observe-only runtime checker that sits beside the pipelined CPU core and
// evaluates seven pipeline invariants every cycle. Each invariant has its own
// runtime enable. Violations are reported as registered one-cycle pulses,
// sticky flags, a saturating violation-cycle counter and a first-failure
// record (check index plus the fetch PC at that moment). A stall-run counter
// doubles as the input to the stall watchdog check.
//
// Check indices:
//   0 PC_ALIGN    fetch PC not word aligned
//   1 X0_CORRUPT  register x0 holds a non-zero value
//   2 MEM_EXCL    MEM stage asserts load and store together
//   3 LOAD_USE    load-use hazard in ID that was not stalled
//   4 STALL_PC    fetch PC moved by something other than 0 or +4 while stalled
//   5 FWD_X0      forwarding selected for a source that is x0
//   6 STALL_WDOG  stall run longer than STALL_MAX cycles
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_pc, if_stall          fetch PC and fetch/decode stall
//   rf_x0                    register-file entry 0
//   mem_memread/memwrite     MEM-stage load/store strobes
//   ex_memread, ex_rs, ex_rt EX-stage load strobe and source indices
//   id_rs, id_rt             ID-stage source indices
//   fwd_a, fwd_b             forwarding mux selects
//   chk_en                   per-check enable
//   clr                      synchronous clear of sticky/count/first record
//   err_pulse                registered per-check violation (one cycle)
//   err_sticky, err_any      sticky per-check flags and their OR
//   err_cnt                  saturating count of cycles with any violation
//   first_valid/id/pc        first-failure record
//   stall_run                current consecutive-stall count
// ---------------------------------------------------------------------------
module pipe_invariant_monitor #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 16,
    parameter int STALL_W   = 8,
    parameter int STALL_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     if_pc,
    input  logic                if_stall,
    input  logic [XLEN-1:0]     rf_x0,
    input  logic                mem_memread,
    input  logic                mem_memwrite,
    input  logic                ex_memread,
    input  logic [REG_AW-1:0]   ex_rs,
    input  logic [REG_AW-1:0]   ex_rt,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic [1:0]          fwd_a,
    input  logic [1:0]          fwd_b,
    input  logic [6:0]          chk_en,
    input  logic                clr,
    output logic [6:0]          err_pulse,
    output logic [6:0]          err_sticky,
    output logic                err_any,
    output logic [CNT_W-1:0]    err_cnt,
    output logic                first_valid,
    output logic [2:0]          first_id,
    output logic [XLEN-1:0]     first_pc,
    output logic [STALL_W-1:0]  stall_run
);

    localparam int NCHK = 7;

    typedef enum logic [2:0] {
        CHK_PC_ALIGN   = 3'd0,
        CHK_X0_CORRUPT = 3'd1,
        CHK_MEM_EXCL   = 3'd2,
        CHK_LOAD_USE   = 3'd3,
        CHK_STALL_PC   = 3'd4,
        CHK_FWD_X0     = 3'd5,
        CHK_STALL_WDOG = 3'd6
    } chk_id_e;

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [STALL_W-1:0] RUN_MAX   = '1;
    localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);
    localparam logic [XLEN-1:0]    PC_STEP   = XLEN'(4);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [XLEN-1:0]    pc_prev_q;
    logic               pc_prev_valid_q;
    logic [STALL_W-1:0] stall_run_q,   stall_run_d;
    logic [NCHK-1:0]    err_pulse_q;
    logic [NCHK-1:0]    err_sticky_q,  err_sticky_d;
    logic [CNT_W-1:0]   err_cnt_q,     err_cnt_d;
    logic               first_valid_q, first_valid_d;
    logic [2:0]         first_id_q,    first_id_d;
    logic [XLEN-1:0]    first_pc_q,    first_pc_d;

    logic [NCHK-1:0]    raw;
    logic [NCHK-1:0]    viol;
    logic               any_viol;
    logic [2:0]         low_id;

    // -----------------------------------------------------------------------
    // Raw invariant evaluation on the current inputs
    // -----------------------------------------------------------------------
    // NOTE: every signal driven in an always_comb gets a default on entry so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        raw = '0;

        raw[CHK_PC_ALIGN]   = |if_pc[1:0];
        raw[CHK_X0_CORRUPT] = |rf_x0;
        raw[CHK_MEM_EXCL]   = mem_memread && mem_memwrite;

        // A load targeting x0 writes nothing, so it can never create a hazard.
        raw[CHK_LOAD_USE]   = ex_memread && (ex_rt != '0) &&
                              ((ex_rt == id_rs) || (ex_rt == id_rt)) &&
                              !if_stall;

        // While stalled the fetch PC may hold or advance by exactly one word;
        // the +4 wraps at XLEN bits. The first cycle after reset has no
        // previous PC to compare against.
        raw[CHK_STALL_PC]   = if_stall && pc_prev_valid_q &&
                              (if_pc != pc_prev_q) &&
                              (if_pc != (pc_prev_q + PC_STEP));

        raw[CHK_FWD_X0]     = ((fwd_a != 2'b00) && (ex_rs == '0)) ||
                              ((fwd_b != 2'b00) && (ex_rt == '0));

        // stall_run_q counts stalls already completed, so the comparison
        // fires on stall cycle STALL_MAX+1 and every cycle after it.
        raw[CHK_STALL_WDOG] = if_stall && (stall_run_q >= STALL_LIM);
    end

    assign viol     = raw & chk_en;
    assign any_viol = |viol;

    // Lowest failing index wins: scan from the top down so the last hit is
    // the smallest index.
    always_comb begin
        low_id = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (viol[i]) begin
                low_id = 3'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // Stall-run counter ignores clr: it reflects the pipeline, not status.
        stall_run_d = '0;
        if (if_stall) begin
            stall_run_d = (stall_run_q == RUN_MAX) ? stall_run_q
                                                   : stall_run_q + 1'b1;
        end

        err_sticky_d  = err_sticky_q;
        err_cnt_d     = err_cnt_q;
        first_valid_d = first_valid_q;
        first_id_d    = first_id_q;
        first_pc_d    = first_pc_q;

        // clr takes priority over a same-cycle violation for all status
        // state; err_pulse is not part of this and still reports it.
        if (clr) begin
            err_sticky_d  = '0;
            err_cnt_d     = '0;
            first_valid_d = 1'b0;
            first_id_d    = '0;
            first_pc_d    = '0;
        end else begin
            err_sticky_d = err_sticky_q | viol;

            // One increment per failing cycle, however many checks fail.
            if (any_viol && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end

            if (any_viol && !first_valid_q) begin
                first_valid_d = 1'b1;
                first_id_d    = low_id;
                first_pc_d    = if_pc;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_prev_q       <= '0;
            pc_prev_valid_q <= 1'b0;
            stall_run_q     <= '0;
            err_pulse_q     <= '0;
            err_sticky_q    <= '0;
            err_cnt_q       <= '0;
            first_valid_q   <= 1'b0;
            first_id_q      <= '0;
            first_pc_q      <= '0;
        end else begin
            pc_prev_q       <= if_pc;
            pc_prev_valid_q <= 1'b1;
            stall_run_q     <= stall_run_d;
            err_pulse_q     <= viol;
            err_sticky_q    <= err_sticky_d;
            err_cnt_q       <= err_cnt_d;
            first_valid_q   <= first_valid_d;
            first_id_q      <= first_id_d;
            first_pc_q      <= first_pc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign err_pulse   = err_pulse_q;
    assign err_sticky  = err_sticky_q;
    assign err_any     = |err_sticky_q;
    assign err_cnt     = err_cnt_q;
    assign first_valid = first_valid_q;
    assign first_id    = first_id_q;
    assign first_pc    = first_pc_q;
    assign stall_run   = stall_run_q;

endmodule

// File: tb/tb_pipe_invariant_monitor.sv
// ---------------------------------------------------------------------------
// Testbench for pipe_invariant_monitor. A driver applies one stimulus vector
// per cycle on the falling edge, advances a behavioural model of the checker
// and queues the expected outputs for the following rising edge. A separate
// monitor compares the DUT just after that edge. A few directed points also
// check hand-derived constants.
// ---------------------------------------------------------------------------
module tb_pipe_invariant_monitor;

    localparam int XLEN      = 32;
    localparam int REG_AW    = 5;
    localparam int CNT_W     = 16;
    localparam int STALL_W   = 8;
    localparam int STALL_MAX = 4;
    localparam int CNT_SAT   = (1 << CNT_W) - 1;
    localparam int RUN_SAT   = (1 << STALL_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic [XLEN-1:0]    if_pc;
    logic               if_stall;
    logic [XLEN-1:0]    rf_x0;
    logic               mem_memread, mem_memwrite, ex_memread;
    logic [REG_AW-1:0]  ex_rs, ex_rt, id_rs, id_rt;
    logic [1:0]         fwd_a, fwd_b;
    logic [6:0]         chk_en;
    logic               clr;
    logic [6:0]         err_pulse, err_sticky;
    logic               err_any;
    logic [CNT_W-1:0]   err_cnt;
    logic               first_valid;
    logic [2:0]         first_id;
    logic [XLEN-1:0]    first_pc;
    logic [STALL_W-1:0] stall_run;

    always #5 clk = ~clk;

    pipe_invariant_monitor #(
        .XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W),
        .STALL_W(STALL_W), .STALL_MAX(STALL_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_pc(if_pc), .if_stall(if_stall), .rf_x0(rf_x0),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .ex_memread(ex_memread), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .chk_en(chk_en), .clr(clr),
        .err_pulse(err_pulse), .err_sticky(err_sticky), .err_any(err_any),
        .err_cnt(err_cnt), .first_valid(first_valid), .first_id(first_id),
        .first_pc(first_pc), .stall_run(stall_run)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        stall;
        logic [31:0] x0;
        logic        mr, mw, exmr;
        logic [4:0]  ex_rs, ex_rt, id_rs, id_rt;
        logic [1:0]  fa, fb;
        logic [6:0]  en;
        logic        clr;
    } stim_t;

    typedef struct packed {
        int unsigned cyc;
        logic [6:0]  pulse;
        logic [6:0]  sticky;
        logic        any;
        logic [15:0] cnt;
        logic        fv;
        logic [2:0]  fid;
        logic [31:0] fpc;
        logic [7:0]  run;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_pc_prev;
    bit          m_pc_valid;
    int          m_run;
    bit [6:0]    m_sticky;
    int          m_cnt;
    bit          m_fv;
    int          m_fid;
    logic [31:0] m_fpc;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc_prev  = '0;
        m_pc_valid = 1'b0;
        m_run      = 0;
        m_sticky   = '0;
        m_cnt      = 0;
        m_fv       = 1'b0;
        m_fid      = 0;
        m_fpc      = '0;
    endtask

    // Invariant rules written directly from their definitions.
    function automatic bit [6:0] rules(input stim_t s);
        bit [6:0] r;
        r    = '0;
        r[0] = (s.pc % 4) != 0;
        r[1] = s.x0 != 0;
        r[2] = s.mr && s.mw;
        r[3] = s.exmr && s.ex_rt != 0 && (s.ex_rt == s.id_rs || s.ex_rt == s.id_rt)
               && !s.stall;
        r[4] = s.stall && m_pc_valid && s.pc != m_pc_prev
               && s.pc != 32'(m_pc_prev + 32'd4);
        r[5] = (s.fa != 0 && s.ex_rs == 0) || (s.fb != 0 && s.ex_rt == 0);
        r[6] = s.stall && m_run >= STALL_MAX;
        return r & s.en;
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s       = '0;
        s.pc    = (m_pc_prev & ~32'd3) + 32'd4;
        s.en    = 7'h7F;
        return s;
    endfunction

    // Call on a falling edge; returns on the next falling edge.
    task automatic apply(input stim_t s, input bit push);
        bit [6:0] v;
        bit       found;
        exp_t     e;
        if_pc = s.pc;  if_stall = s.stall;  rf_x0 = s.x0;
        mem_memread = s.mr;  mem_memwrite = s.mw;  ex_memread = s.exmr;
        ex_rs = s.ex_rs;  ex_rt = s.ex_rt;  id_rs = s.id_rs;  id_rt = s.id_rt;
        fwd_a = s.fa;  fwd_b = s.fb;  chk_en = s.en;  clr = s.clr;

        v = rules(s);
        if (s.clr) begin
            m_sticky = '0; m_cnt = 0; m_fv = 1'b0; m_fid = 0; m_fpc = '0;
        end else begin
            m_sticky |= v;
            if (v != 0 && m_cnt < CNT_SAT) m_cnt++;
            if (v != 0 && !m_fv) begin
                m_fv  = 1'b1;
                m_fpc = s.pc;
                found = 1'b0;
                for (int i = 0; i < 7; i++) begin
                    if (v[i] && !found) begin
                        m_fid = i;
                        found = 1'b1;
                    end
                end
            end
        end
        m_run      = s.stall ? ((m_run < RUN_SAT) ? m_run + 1 : m_run) : 0;
        m_pc_prev  = s.pc;
        m_pc_valid = 1'b1;

        if (push) begin
            e.cyc    = cyc + 1;
            e.pulse  = v;
            e.sticky = m_sticky;
            e.any    = (m_sticky != 0);
            e.cnt    = 16'(m_cnt);
            e.fv     = m_fv;
            e.fid    = 3'(m_fid);
            e.fpc    = m_fpc;
            e.run    = 8'(m_run);
            sb_q.push_back(e);
        end
        @(negedge clk);
    endtask

    // Monitor: compare queued expectations just after the rising edge they
    // belong to.
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            if (e.cyc < cyc) begin
                check("sb_stale_entry", 64'(e.cyc), 64'(cyc));
            end else begin
                check("err_pulse",   64'(err_pulse),   64'(e.pulse));
                check("err_sticky",  64'(err_sticky),  64'(e.sticky));
                check("err_any",     64'(err_any),     64'(e.any));
                check("err_cnt",     64'(err_cnt),     64'(e.cnt));
                check("first_valid", 64'(first_valid), 64'(e.fv));
                check("first_id",    64'(first_id),    64'(e.fid));
                check("first_pc",    64'(first_pc),    64'(e.fpc));
                check("stall_run",   64'(stall_run),   64'(e.run));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_pulse"},  64'(err_pulse),   64'd0);
        check({tag, "_sticky"}, 64'(err_sticky),  64'd0);
        check({tag, "_any"},    64'(err_any),     64'd0);
        check({tag, "_cnt"},    64'(err_cnt),     64'd0);
        check({tag, "_fv"},     64'(first_valid), 64'd0);
        check({tag, "_fid"},    64'(first_id),    64'd0);
        check({tag, "_fpc"},    64'(first_pc),    64'd0);
        check({tag, "_run"},    64'(stall_run),   64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        stim_t s;
        model_reset();
        rst = 1'b1;
        if_pc = '0; if_stall = 0; rf_x0 = '0; mem_memread = 0; mem_memwrite = 0;
        ex_memread = 0; ex_rs = '0; ex_rt = '0; id_rs = '0; id_rt = '0;
        fwd_a = '0; fwd_b = '0; chk_en = 7'h7F; clr = 0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Aligned PCs 0, 4, 8 ... with every check enabled.
        s = idle_stim(); s.pc = 32'h0;
        apply(s, 1'b1);
        repeat (19) apply(idle_stim(), 1'b1);
        check("clean_err_cnt", 64'(err_cnt), 64'd0);
        check("clean_err_any", 64'(err_any), 64'd0);

        // Misaligned PC for one cycle.
        s = idle_stim(); s.pc = 32'h6;
        apply(s, 1'b1);
        check("align_pulse",  64'(err_pulse),  64'h01);
        check("align_sticky", 64'(err_sticky), 64'h01);
        check("align_fid",    64'(first_id),   64'd0);
        check("align_fpc",    64'(first_pc),   64'h6);
        check("align_cnt",    64'(err_cnt),    64'd1);
        apply(idle_stim(), 1'b1);

        // Load-use hazard plus forward-from-x0 in the same cycle.
        s = idle_stim(); s.clr = 1'b1; apply(s, 1'b1);
        s = idle_stim(); s.exmr = 1; s.ex_rt = 5'd5; s.id_rs = 5'd5;
        s.fa = 2'b01; s.ex_rs = 5'd0;
        apply(s, 1'b1);
        check("lu_pulse", 64'(err_pulse), 64'b0101000);
        check("lu_fid",   64'(first_id),  64'd3);
        check("lu_cnt",   64'(err_cnt),   64'd1);
        s = idle_stim(); s.clr = 1'b1; apply(s, 1'b1);
        s = idle_stim(); s.exmr = 1; s.ex_rt = 5'd0; s.id_rs = 5'd0;
        s.fa = 2'b01; s.ex_rs = 5'd0;
        apply(s, 1'b1);
        check("lu_x0_pulse", 64'(err_pulse), 64'b0100000);

        // Six-cycle stall with the PC held: watchdog on cycles 5 and 6 only.
        s = idle_stim(); s.clr = 1'b1; apply(s, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            s = idle_stim(); s.pc = m_pc_prev; s.stall = 1'b1;
            apply(s, 1'b1);
            check("wdog_pulse6", 64'(err_pulse[6]), 64'(k >= 5));
        end
        check("wdog_run", 64'(stall_run), 64'd6);
        check("wdog_cnt", 64'(err_cnt),   64'd2);
        apply(idle_stim(), 1'b1);

        // Stall-PC rule across the 32-bit wrap.
        s = idle_stim(); s.clr = 1'b1; s.pc = 32'hFFFF_FFFC; apply(s, 1'b1);
        s = idle_stim(); s.stall = 1'b1; s.pc = 32'h0;
        apply(s, 1'b1);
        check("wrap_legal_pulse", 64'(err_pulse), 64'd0);
        s = idle_stim(); s.stall = 1'b1; s.pc = 32'h8;
        apply(s, 1'b1);
        check("stall_pc_pulse", 64'(err_pulse), 64'b0010000);
        apply(idle_stim(), 1'b1);

        // Counter saturation under a continuous MEM_EXCL violation.
        s = idle_stim(); s.clr = 1'b1; apply(s, 1'b1);
        for (int i = 0; i < 70000; i++) begin
            s = idle_stim(); s.mr = 1'b1; s.mw = 1'b1;
            apply(s, (i % 4096 == 0) || (i > 69990));
        end
        check("sat_cnt", 64'(err_cnt), 64'hFFFF);
        s = idle_stim(); s.mr = 1'b1; s.mw = 1'b1; s.clr = 1'b1;
        apply(s, 1'b1);
        check("clr_cnt",    64'(err_cnt),      64'd0);
        check("clr_sticky", 64'(err_sticky),   64'd0);
        check("clr_fv",     64'(first_valid),  64'd0);
        check("clr_pulse2", 64'(err_pulse[2]), 64'd1);

        // Runtime enable, then asynchronous reset mid-sequence.
        s = idle_stim(); s.x0 = 32'h1; s.en = 7'h7D;
        apply(s, 1'b1);
        check("en_off_pulse", 64'(err_pulse), 64'd0);
        s = idle_stim(); s.x0 = 32'h1;
        apply(s, 1'b1);
        check("en_on_pulse", 64'(err_pulse), 64'b0000010);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s = idle_stim();
            s.stall = ($urandom_range(0, 99) < 30);
            if (s.stall && $urandom_range(0, 99) < 80) s.pc = m_pc_prev;
            else if ($urandom_range(0, 99) < 10) s.pc = 32'($urandom_range(0, 255));
            s.x0    = ($urandom_range(0, 99) < 3) ? 32'($urandom) : 32'd0;
            s.mr    = ($urandom_range(0, 99) < 20);
            s.mw    = ($urandom_range(0, 99) < 20);
            s.exmr  = ($urandom_range(0, 99) < 30);
            s.ex_rs = 5'($urandom_range(0, 3));
            s.ex_rt = 5'($urandom_range(0, 3));
            s.id_rs = 5'($urandom_range(0, 3));
            s.id_rt = 5'($urandom_range(0, 3));
            s.fa    = ($urandom_range(0, 99) < 60) ? 2'd0 : 2'($urandom_range(1, 3));
            s.fb    = ($urandom_range(0, 99) < 60) ? 2'd0 : 2'($urandom_range(1, 3));
            s.en    = ($urandom_range(0, 99) < 80) ? 7'h7F : 7'($urandom);
            s.clr   = ($urandom_range(0, 99) < 3);
            apply(s, 1'b1);
        end

        repeat (2) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
